muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
//
// PURPOSE
// Sequencer for the multi-cycle multiply and divide datapaths. It takes a
// MULT/DIV request from the CPU control unit, latches the operands, holds the
// selected unit's init line for a fixed cycle count, then captures HI/LO.
// It stalls the pipeline via busy, reports completion, and handles
// divide-by-zero and exception flush.
//
// PARAMETERS
// MULT_CYCLES  32  RUN cycles the multiplier needs after its load cycle
// DIV_CYCLES   32  RUN cycles the divider needs after its load cycle
// CNT_W        6   cycle-counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
//
// PORTS
// clk         in   1   clock, rising edge
// reset       in   1   asynchronous, active-high reset
// op_start    in   1   request from the control unit, sampled at clk edge
// op_sel      in   1   0 = MULT, 1 = DIV
// flush       in   1   synchronous abort (exception); no HI/LO write
// value_A     in   32  operand A (multiplicand / dividend)
// value_B     in   32  operand B (multiplier / divisor)
// op_a        out  32  latched operand A to both units
// op_b        out  32  latched operand B to both units
// mult_init   out  1   multInit of the multiplier; high in LOAD and RUN for MULT
// div_init    out  1   divInit of the divider; high in LOAD and RUN for DIV
// mult_hi     in   32  multiplier HI result
// mult_lo     in   32  multiplier LO result
// div_hi      in   32  divider remainder
// div_lo      in   32  divider quotient
// busy        out  1   stall request; high in LOAD and RUN
// done        out  1   one-cycle completion pulse (high in DONE)
// div_zero    out  1   sticky: last accepted DIV had value_B == 0
// hi          out  32  architectural HI register
// lo          out  32  architectural LO register
//
// BEHAVIOUR
// - Reset (async): state = IDLE, cnt = 0. op_a, op_b, hi, lo = 0.
//   mult_init, div_init, busy, done and div_zero = 0.
// - FSM states: IDLE, LOAD, RUN, DONE. DONE accepts op_start exactly like IDLE.
// - IDLE/DONE + op_start = 1:
//   - Latch op_a <= value_A, op_b <= value_B, and the op type; clear div_zero.
//   - DIV with value_B == 0 -> DONE directly. Set div_zero = 1.
//     No init line is raised and hi/lo are unchanged.
//   - Otherwise -> LOAD.
// - IDLE/DONE without op_start -> IDLE. done is low in every state except DONE.
// - LOAD (1 cycle): raise the selected init line. Load cnt with
//   MULT_CYCLES-1 or DIV_CYCLES-1. -> RUN.
// - RUN: init line stays high. cnt decrements each cycle.
//   - On the edge where cnt == 0: hi/lo <= selected unit's (hi, lo);
//     for DIV, lo = quotient and hi = remainder. -> DONE.
// - Latency: done is high exactly N+2 edges after the edge that accepted
//   op_start (N = MULT_CYCLES or DIV_CYCLES). hi/lo are valid in that same
//   cycle. Divide-by-zero: done after 1 edge.
// - op_start while busy is ignored. It is not queued, and the operands are
//   not relatched.
// - flush in LOAD/RUN -> IDLE on the next edge. Init lines drop with it.
//   No hi/lo write, no done. flush beats op_start in IDLE/DONE, and the
//   request is dropped.
// - Init lines, busy and done are decoded from registered state and are
//   glitch-free. op_a/op_b are stable from LOAD until the next accept.
// - Async reset mid-operation: all outputs return to reset values
//   immediately. The units see init low and must restart cleanly.
//
// TESTING
// - MULT 7 x -3 (0xFFFFFFFD) -> busy for 33 cycles; done at edge 34;
//   hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
// - DIV 100 / 7 -> done at edge 34; lo = 14, hi = 2; div_init high for
//   33 cycles; mult_init stays 0.
// - DIV 5 / 0 -> done at edge 1, div_zero = 1, hi/lo unchanged; a following
//   MULT 2 x 3 clears div_zero, then lo = 6 and hi = 0.
// - op_start with A=9, B=9 pulsed at RUN cycle 10 of MULT 4 x 5 -> ignored;
//   lo = 20; exactly one done pulse.
// - flush at RUN cycle 5 of MULT 3 x 3 -> IDLE next edge, no done,
//   hi/lo keep their prior values.
// - reset asserted mid-RUN, async between edges -> busy, init and done are
//   0 before the next edge, hi/lo = 0; a new op afterwards completes correctly.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Sequencer for the multi-cycle multiply/divide units: latches operands, holds the
// selected unit's init line for a fixed cycle count, then captures HI/LO.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_sel,
  input  logic        flush,
  input  logic [31:0] value_A,
  input  logic [31:0] value_B,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mult_init,
  output logic        div_init,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             is_div;
  logic             accept;
  logic             finish;
  logic             b_zero;

  assign b_zero = (value_B == 32'd0);

  // Handshake: op_start is sampled on every edge in IDLE/DONE (the only states
  // where busy is low); a request seen while busy is dropped, never queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (op_start) begin
          accept   = 1'b1;
          state_nx = (op_sel && b_zero) ? DONE : LOAD;
        end else begin
          state_nx = IDLE;
        end
      end
      LOAD: begin
        if (flush) begin
          state_nx = IDLE;
        end else begin
          cnt_nx   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          state_nx = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          finish   = 1'b1;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a     <= '0;
      op_b     <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (accept) begin
        op_a     <= value_A;
        op_b     <= value_B;
        is_div   <= op_sel;
        div_zero <= op_sel && b_zero;
      end
      if (finish) begin
        hi <= is_div ? div_hi : mult_hi;
        lo <= is_div ? div_lo : mult_lo;
      end
    end
  end

  // Control outputs decode straight from the state register, so they cannot glitch.
  assign busy      = (state == LOAD) || (state == RUN);
  assign mult_init = busy && !is_div;
  assign div_init  = busy && is_div;
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: the multiply/divide units are stood in for by
// hand-set result inputs, with the other unit driven to a distinct dummy value.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_start, op_sel, flush;
  logic [31:0] value_A, value_B;
  logic [31:0] op_a, op_b;
  logic        mult_init, div_init;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic [1:0]  state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel), .flush(flush),
    .value_A(value_A), .value_B(value_B), .op_a(op_a), .op_b(op_b),
    .mult_init(mult_init), .div_init(div_init),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: present a request for exactly one edge (the accept edge, edge 1)
  task automatic start_op(input logic sel, input logic [31:0] a, input logic [31:0] b);
    op_start = 1'b1;
    op_sel   = sel;
    value_A  = a;
    value_B  = b;
    tick();
    op_start = 1'b0;
    value_A  = $urandom;
    value_B  = $urandom;
  endtask

  task automatic wait_done(output int edges, output int busy_c, output int mi_c, output int di_c);
    edges = 1; busy_c = 0; mi_c = 0; di_c = 0;
    while (!done && edges < 200) begin
      busy_c += int'(busy);
      mi_c   += int'(mult_init);
      di_c   += int'(div_init);
      tick();
      edges++;
    end
  endtask

  // scoreboard: compares captured {hi, lo} with the oldest expected result
  task automatic check_result(input string tag);
    logic [63:0] e;
    e = exp_q.pop_front();
    check({tag, "_hi"}, hi, e[63:32]);
    check({tag, "_lo"}, lo, e[31:0]);
  endtask

  int edges, busy_c, mi_c, di_c, pulses;

  initial begin
    reset = 1'b1; op_start = 1'b0; op_sel = 1'b0; flush = 1'b0;
    value_A = '0; value_B = '0;
    mult_hi = '0; mult_lo = '0; div_hi = '0; div_lo = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_init", {30'd0, mult_init, div_init}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // MULT 7 x -3
    mult_hi = 32'hFFFF_FFFF; mult_lo = 32'hFFFF_FFEB;
    div_hi = 32'hDEAD_0001; div_lo = 32'hDEAD_0002;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
    start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    check("mul_opa", op_a, 32'd7);
    check("mul_opb", op_b, 32'hFFFF_FFFD);
    wait_done(edges, busy_c, mi_c, di_c);
    check("mul_edges", 32'(edges), 32'd34);
    check("mul_busy", 32'(busy_c), 32'd33);
    check("mul_minit", 32'(mi_c), 32'd33);
    check("mul_dinit", 32'(di_c), 32'd0);
    check("mul_done", {31'd0, done}, 32'd1);
    check_result("mul");
    tick();
    check("mul_pulse", {31'd0, done}, 32'd0);
    check("mul_idle", {30'd0, state_dbg}, 32'd0);

    // DIV 100 / 7
    div_hi = 32'd2; div_lo = 32'd14;
    mult_hi = 32'hBEEF_0001; mult_lo = 32'hBEEF_0002;
    exp_q.push_back({32'd2, 32'd14});
    start_op(1'b1, 32'd100, 32'd7);
    wait_done(edges, busy_c, mi_c, di_c);
    check("div_edges", 32'(edges), 32'd34);
    check("div_dinit", 32'(di_c), 32'd33);
    check("div_minit", 32'(mi_c), 32'd0);
    check("div_dz", {31'd0, div_zero}, 32'd0);
    check_result("div");

    // DIV 5 / 0: immediate DONE, results untouched
    div_hi = 32'h1111_1111; div_lo = 32'h2222_2222;
    start_op(1'b1, 32'd5, 32'd0);
    check("dz_done", {31'd0, done}, 32'd1);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_busy", {31'd0, busy}, 32'd0);
    check("dz_dinit", {31'd0, div_init}, 32'd0);
    check("dz_hi", hi, 32'd2);
    check("dz_lo", lo, 32'd14);

    // MULT 2 x 3 accepted straight from DONE clears div_zero
    mult_hi = 32'd0; mult_lo = 32'd6;
    exp_q.push_back({32'd0, 32'd6});
    start_op(1'b0, 32'd2, 32'd3);
    check("m23_dz", {31'd0, div_zero}, 32'd0);
    check("m23_busy", {31'd0, busy}, 32'd1);
    wait_done(edges, busy_c, mi_c, di_c);
    check("m23_edges", 32'(edges), 32'd34);
    check_result("m23");
    tick();

    // flush beats op_start in IDLE
    flush = 1'b1;
    start_op(1'b0, 32'd77, 32'd88);
    flush = 1'b0;
    check("fidle_busy", {31'd0, busy}, 32'd0);
    check("fidle_opa", op_a, 32'd2);

    // op_start while busy (RUN cycle 10) is ignored
    mult_hi = 32'd0; mult_lo = 32'd20;
    exp_q.push_back({32'd0, 32'd20});
    start_op(1'b0, 32'd4, 32'd5);
    repeat (10) tick();
    start_op(1'b0, 32'd9, 32'd9);
    check("ign_opa", op_a, 32'd4);
    check("ign_opb", op_b, 32'd5);
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      pulses += int'(done);
      if (done) check_result("ign");
      tick();
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_busy", {31'd0, busy}, 32'd0);

    // flush at RUN cycle 5 of MULT 3 x 3
    mult_hi = 32'd0; mult_lo = 32'd9;
    start_op(1'b0, 32'd3, 32'd3);
    repeat (5) tick();
    check("fl_run", {30'd0, state_dbg}, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_idle", {30'd0, state_dbg}, 32'd0);
    check("fl_minit", {31'd0, mult_init}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      pulses += int'(done);
      tick();
    end
    check("fl_pulses", 32'(pulses), 32'd0);
    check("fl_lo", lo, 32'd20);

    // async reset mid-RUN, then a fresh DIV completes
    start_op(1'b0, 32'd6, 32'd6);
    repeat (8) tick();
    #3 reset = 1'b1;
    #1;
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_init", {30'd0, mult_init, div_init}, 32'd0);
    check("ar_done", {31'd0, done}, 32'd0);
    check("ar_lo", lo, 32'd0);
    check("ar_opa", op_a, 32'd0);
    #2 reset = 1'b0;
    tick();
    div_hi = 32'd2; div_lo = 32'd14;
    exp_q.push_back({32'd2, 32'd14});
    start_op(1'b1, 32'd100, 32'd7);
    wait_done(edges, busy_c, mi_c, di_c);
    check("ar2_edges", 32'(edges), 32'd34);
    check_result("ar2");

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
